// File: rtl/case_conv_arbiter.sv
// case_conv_arbiter: two-channel round-robin arbiter feeding a shared ASCII case converter with a registered output and a converted-letter counter
module case_conv_arbiter #(
  parameter int CNT_W   = 16,
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [7:0]         req_data0,
  input  logic [7:0]         req_data1,
  input  logic [1:0]         req_mode0,
  input  logic [1:0]         req_mode1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_src,
  output logic               out_cap,
  output logic [CNT_W-1:0]   conv_cnt,
  input  logic               clr_cnt
);
  logic             valid_q, valid_d, src_q, src_d, cap_q, cap_d, rr_q, rr_d;
  logic [7:0]       data_q, data_d, sel_data, conv_data;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_mode;
  logic             can_accept, fire, win, letter, flip;
  always_comb begin
    can_accept = !valid_q | out_ready;
    // rst_n gating forces req_ready low while reset is held
    fire       = can_accept & (|req_valid) & rst_n;
    win        = (req_valid == 2'b11) ? rr_q : req_valid[1];
    req_ready  = fire ? (win ? 2'b10 : 2'b01) : 2'b00;
    sel_data   = win ? req_data1 : req_data0;
    sel_mode   = win ? req_mode1 : req_mode0;
    letter     = (sel_data[7:6] == 2'b01) && (sel_data[4:0] != 5'd0) && (sel_data[4:0] <= 5'd26);
    flip       = letter & ((sel_mode == 2'b11) | ((sel_mode == 2'b01) & sel_data[5]) | ((sel_mode == 2'b10) & !sel_data[5]));
    conv_data  = sel_data ^ {2'b00, flip, 5'b00000};
    valid_d    = fire ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    data_d     = fire ? conv_data : data_q;
    src_d      = fire ? win : src_q;
    cap_d      = fire ? (letter & !conv_data[5]) : cap_q;
    rr_d       = fire ? !win : rr_q;
    cnt_d      = clr_cnt ? '0 : ((fire & flip & !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      src_q   <= 1'b0;
      cap_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cap_q   <= cap_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_cap   = cap_q;
  assign conv_cnt  = cnt_q;
endmodule

// File: doc/case_conv_arbiter.md
Name: case_conv_arbiter

Overview:
- Shares one ASCII case-conversion datapath (bit-5 flip on letters) between two requester channels.
- Round-robin arbitration between the channels, with a per-request conversion mode.
- One registered output stage with a valid/ready handshake.
- A saturating counter of converted letters, for status readback in the character-stream pipeline.

Parameters:
CNT_W, 16, width of the converted-letter counter
NUM_REQ, 2, number of requester channels (fixed at 2; other values unsupported)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-channel request valid (bit i = channel i)
req_ready  output  2  per-channel accept; a transfer occurs when valid&ready
req_data0  input  8  channel 0 character
req_data1  input  8  channel 1 character
req_mode0  input  2  channel 0 mode: 00 pass, 01 to-upper, 10 to-lower, 11 toggle
req_mode1  input  2  channel 1 mode
out_valid  output  1  output register holds a result
out_ready  input  1  downstream accept
out_data  output  8  converted character
out_src  output  1  channel the result came from
out_cap  output  1  1 when out_data is an uppercase letter (0x41-0x5A)
conv_cnt  output  CNT_W  number of characters whose value was changed, saturating
clr_cnt  input  1  synchronous clear of conv_cnt

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_src=0, out_cap=0, conv_cnt=0, rr_ptr=0. req_ready is combinational and goes to 0 during reset.
- Letter test: bits [4:0] in 1..26 and bits [7:6]=01.
  - Uppercase = letter with bit5=0; lowercase = letter with bit5=1.
  - Non-letters always pass unchanged in every mode.
- Conversion:
  - pass: unchanged.
  - upper: clear bit5 if lowercase.
  - lower: set bit5 if uppercase.
  - toggle: invert bit5 if letter.
  - All other bits are untouched.
- Output register:
  - can_accept = !out_valid | out_ready.
  - Exactly one channel is granted per cycle when can_accept and any req_valid is high.
  - req_ready[i] = can_accept & grant[i]; req_ready is never high for a non-granted channel.
- Arbitration:
  - Only one channel valid: that channel wins.
  - Both valid: channel rr_ptr wins, then rr_ptr <= ~winner.
  - rr_ptr changes only on an accepted transfer.
  - No grant is issued when can_accept=0, and rr_ptr holds.
- Latency: one cycle. A result accepted at edge N appears on out_* after edge N.
- Back-to-back: full throughput of 1/cycle while out_ready=1.
  - Simultaneous drain and load in one cycle keeps out_valid=1 with the new data.
- Hold: while out_valid=1 and out_ready=0, out_data/out_src/out_cap are stable.
- Drain with no new request: out_valid <= 0; out_data holds its last value.
- conv_cnt:
  - Increments by 1 on each accepted transfer where the converted value differs from the input.
  - Saturates at all-ones.
  - clr_cnt has priority over an increment in the same cycle (result 0).
- Reset mid-transfer: the pending output is discarded; no partial state survives.
- Requester rules: a requester must hold valid/data/mode stable until accepted. The block does not check this.

Test Plan:
1. Reset then single request: ch0 valid, data 0x61, mode 01, out_ready=1 -> next cycle out_valid=1, out_data=0x41, out_src=0, out_cap=1, conv_cnt=1.
2. Non-letters: ch1 sends 0x40, 0x5B, 0x7B, 0x31 in toggle mode -> outputs identical to inputs, out_cap=0, conv_cnt unchanged.
3. Contention: both channels continuously valid, out_ready=1 -> grants alternate 0,1,0,1 starting with ch0 after reset; each channel's req_ready is high on alternate cycles.
4. Backpressure: out_ready=0 with both channels valid -> out_data held, req_ready=00, rr_ptr frozen; on release, the next grant goes to the channel pointed to before the stall.
5. Counter saturation: CNT_W=4, 20 changed conversions -> conv_cnt=15. Assert clr_cnt together with a converting transfer -> conv_cnt=0.
6. Async reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately. After release, no stale result is emitted and rr_ptr=0.
